// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter:
// FSM encoding, digit geometry and the largest value four digits can show.
package bcd_pkg;

  localparam int NDIG    = 4;
  localparam int DIG_W   = 4;
  localparam int EXT_W   = 2;
  localparam int SCR_W   = NDIG * DIG_W + EXT_W;
  localparam int BCD_MAX = 9999;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  typedef logic [DIG_W-1:0] digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// next left shift so it carries correctly into the following decade.
module bcd_add3
  import bcd_pkg::*;
(
  input  digit_t value,
  output digit_t adjusted
);

  assign adjusted = (value >= digit_t'(5)) ? value + digit_t'(3) : value;

endmodule

// File: rtl/bcd_seq_convert.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a
// start/busy/done handshake and optional auto-conversion on input change.
module bcd_seq_convert
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit AUTO  = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam bit              CAN_OVF  = (WIDTH >= 14);

  logic [1:0]            state;
  logic [WIDTH-1:0]      captured;
  logic [WIDTH-1:0]      shift_reg;
  logic [SCR_W-1:0]      scratch;
  logic [SCR_W-1:0]      scratch_next;
  logic [NDIG*DIG_W-1:0] adjusted;
  logic [CNT_W-1:0]      cnt;
  logic                  trigger;
  logic                  saturate;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_add3 u_add3 (
      .value    (scratch[g*DIG_W +: DIG_W]),
      .adjusted (adjusted[g*DIG_W +: DIG_W])
    );
  end

  // The top extension bit is made sticky so an overflow can never shift out unseen.
  assign scratch_next = {scratch[SCR_W-1] | scratch[SCR_W-2], adjusted, shift_reg[WIDTH-1]};
  assign saturate     = CAN_OVF && (scratch_next[SCR_W-1 -: EXT_W] != '0);
  assign trigger      = start || (AUTO && (number != captured));
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      captured  <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      ones      <= '0;
      tens      <= '0;
      hundreds  <= '0;
      thousands <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (trigger) begin
            captured  <= number;
            shift_reg <= number;
            scratch   <= '0;
            cnt       <= CNT_INIT;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_reg << 1;
          if (cnt == '0) begin
            // Outputs load on the final shift so they change in the same cycle done is high.
            state     <= ST_FIN;
            done      <= 1'b1;
            ovf       <= saturate;
            ones      <= saturate ? 4'd9 : scratch_next[3:0];
            tens      <= saturate ? 4'd9 : scratch_next[7:4];
            hundreds  <= saturate ? 4'd9 : scratch_next[11:8];
            thousands <= saturate ? 4'd9 : scratch_next[15:12];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_convert.sv
// Scoreboard bench for bcd_seq_convert: three instances (8-bit manual, 14-bit manual,
// 4-bit auto) checked against an arithmetic decimal reference model.
module tb_bcd_seq_convert;

  typedef struct {
    logic [16:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        start_i [3];
  logic [7:0]  num8;
  logic [13:0] num14;
  logic [3:0]  num4;
  logic        busy_o [3];
  logic        done_o [3];
  logic        ovf_o [3];
  logic [3:0]  ones_o [3];
  logic [3:0]  tens_o [3];
  logic [3:0]  hundreds_o [3];
  logic [3:0]  thousands_o [3];

  exp_t        sb [3][$];
  logic [16:0] last [3];
  int          widths [3] = '{8, 14, 4};
  string       names [3]  = '{"w8", "w14", "w4_auto"};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          cap4 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_seq_convert #(.WIDTH(8), .AUTO(1'b0)) dut8 (
    .clk(clk), .clr(clr), .start(start_i[0]), .number(num8),
    .busy(busy_o[0]), .done(done_o[0]), .ovf(ovf_o[0]),
    .ones(ones_o[0]), .tens(tens_o[0]), .hundreds(hundreds_o[0]), .thousands(thousands_o[0]));

  bcd_seq_convert #(.WIDTH(14), .AUTO(1'b0)) dut14 (
    .clk(clk), .clr(clr), .start(start_i[1]), .number(num14),
    .busy(busy_o[1]), .done(done_o[1]), .ovf(ovf_o[1]),
    .ones(ones_o[1]), .tens(tens_o[1]), .hundreds(hundreds_o[1]), .thousands(thousands_o[1]));

  bcd_seq_convert #(.WIDTH(4), .AUTO(1'b1)) dut4 (
    .clk(clk), .clr(clr), .start(start_i[2]), .number(num4),
    .busy(busy_o[2]), .done(done_o[2]), .ovf(ovf_o[2]),
    .ones(ones_o[2]), .tens(tens_o[2]), .hundreds(hundreds_o[2]), .thousands(thousands_o[2]));

  // Decimal digits by plain division; values above four digits saturate and flag overflow.
  function automatic logic [16:0] ref_model(input int v);
    int   s;
    logic o;
    o = (v > bcd_pkg::BCD_MAX);
    s = o ? bcd_pkg::BCD_MAX : v;
    return {o, 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [16:0] observed(input int i);
    return {ovf_o[i], thousands_o[i], hundreds_o[i], tens_o[i], ones_o[i]};
  endfunction

  task automatic pushExpected(input int i, input int v, input int at_cyc);
    exp_t e;
    e.val = ref_model(v);
    e.cyc = at_cyc;
    sb[i].push_back(e);
  endtask

  task automatic checkOutput(input int i, input exp_t e, input logic [16:0] got);
    checks++;
    if (got !== e.val) begin
      errors++;
      $display("[TB] FAIL %s result: got ovf=%0d digits=%0h%0h%0h%0h, expected ovf=%0d digits=%0h%0h%0h%0h",
               names[i], got[16], got[15:12], got[11:8], got[7:4], got[3:0],
               e.val[16], e.val[15:12], e.val[11:8], e.val[7:4], e.val[3:0]);
    end
    checks++;
    if (cyc != e.cyc) begin
      errors++;
      $display("[TB] FAIL %s latency: done at cycle %0d, expected cycle %0d", names[i], cyc, e.cyc);
    end
  endtask

  task automatic checkValue(input string what, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, got, want);
    end
  endtask

  // Monitor: pops on every done pulse and checks that outputs hold between pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!clr) begin
        if (done_o[i]) begin
          if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s spurious done at cycle %0d", names[i], cyc);
          end else begin
            checkOutput(i, sb[i].pop_front(), observed(i));
          end
        end else begin
          checks++;
          if (observed(i) !== last[i]) begin
            errors++;
            $display("[TB] FAIL %s hold: outputs %0h changed to %0h without done", names[i], last[i], observed(i));
          end
        end
      end
      last[i] = observed(i);
    end
  end

  task automatic applyStimulus(input int i, input int v, input bit with_start);
    bit run;
    @(negedge clk);
    run = with_start || (i == 2 && v != cap4);
    case (i)
      0:       num8  = 8'(v);
      1:       num14 = 14'(v);
      default: num4  = 4'(v);
    endcase
    start_i[i] = with_start;
    if (run) begin
      pushExpected(i, v, cyc + 1 + widths[i]);
      if (i == 2) cap4 = v;
    end
    @(negedge clk);
    start_i[i] = 1'b0;
  endtask

  task automatic waitIdle(input int i);
    int budget = 0;
    while (sb[i].size() != 0 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (sb[i].size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: %0d results never reported", names[i], sb[i].size());
      sb[i].delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int v;
    int c;
    int list14 [5] = '{9999, 12000, 10000, 16383, 0};

    clr = 1'b1;
    num8 = '0;
    num14 = '0;
    num4 = '0;
    for (int i = 0; i < 3; i++) start_i[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      checkValue($sformatf("%s reset state", names[i]),
                 int'({busy_o[i], done_o[i], observed(i)}), 0);
    clr = 1'b0;

    $display("[TB] 8-bit: 255, zero with busy profile, random values");
    applyStimulus(0, 255, 1'b1);
    waitIdle(0);

    @(negedge clk);
    num8 = 8'd0;
    start_i[0] = 1'b1;
    pushExpected(0, 0, cyc + 9);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_i[0] = 1'b0;
      checkValue($sformatf("w8 busy at cycle %0d", k), int'(busy_o[0]), (k <= 9) ? 1 : 0);
    end
    waitIdle(0);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(0, int'($urandom_range(255)), 1'b1);
      waitIdle(0);
    end

    $display("[TB] 8-bit: start while busy is ignored");
    v = int'($urandom_range(255));
    if (v == 77) v = 78;
    applyStimulus(0, v, 1'b1);
    @(negedge clk);
    num8 = 8'd77;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    waitIdle(0);
    repeat (12) @(negedge clk);

    $display("[TB] 14-bit: saturation boundary and random values");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1, list14[n], 1'b1);
      waitIdle(1);
    end
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1, int'($urandom_range(16383)), 1'b1);
      waitIdle(1);
    end

    $display("[TB] 4-bit auto: input changes, start with change, start without change");
    for (int n = 0; n < 6; n++) begin
      applyStimulus(2, int'($urandom_range(15)), n[0]);
      waitIdle(2);
    end
    applyStimulus(2, cap4, 1'b1);
    waitIdle(2);

    if (cap4 == 6) begin
      applyStimulus(2, 3, 1'b0);
      waitIdle(2);
    end
    @(negedge clk);
    c = cyc;
    num4 = 4'd6;
    pushExpected(2, 6, c + 5);
    repeat (2) @(negedge clk);
    num4 = 4'd15;
    pushExpected(2, 15, c + 11);
    cap4 = 15;
    waitIdle(2);

    $display("[TB] clear mid-conversion");
    applyStimulus(0, 123, 1'b1);
    waitIdle(0);
    applyStimulus(2, 9, 1'b0);
    waitIdle(2);
    @(negedge clk);
    num8 = 8'd200;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1 clr = 1'b1;
    #1;
    checkValue("w8 outputs on clear", int'({busy_o[0], done_o[0], observed(0)}), 0);
    checkValue("w4_auto outputs on clear", int'({busy_o[2], done_o[2], observed(2)}), 0);
    @(negedge clk);
    @(negedge clk);
    #1 clr = 1'b0;
    cap4 = 0;
    pushExpected(2, 9, cyc + 5);
    cap4 = 9;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkValue("w8 stays idle after clear", int'(busy_o[0]), 0);
    end
    waitIdle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
